// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one block memory between the I-cache (read-only) and D-cache.
// Each access is registered at grant and held until the memory drops busywait or the ack watchdog fires.
module mem_arbiter #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic              arb_err
);
  typedef enum logic [2:0] {IDLE, ISSUE_I, WAIT_I, RESP_I, ISSUE_D, WAIT_D, RESP_D} state_t;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t          state;
  logic            last_d;
  logic [CW-1:0]   cnt;
  logic            req_i, req_d, win_d, on_d;
  assign req_i      = i_read;
  assign req_d      = d_read | d_write;
  // contention goes to the port that was not served last
  assign win_d      = req_d & (~req_i | ~last_d);
  assign on_d       = (state == ISSUE_D) | (state == WAIT_D);
  assign i_busywait = req_i & (state != RESP_I);
  assign d_busywait = req_d & (state != RESP_D);
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      last_d        <= 1'b0;
      cnt           <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
      arb_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!mem_busywait && (req_i || req_d)) begin
          mem_address   <= win_d ? d_address : i_address;
          mem_writedata <= win_d ? d_writedata : '0;
          mem_read      <= win_d ? ~d_write : 1'b1;
          mem_write     <= win_d & d_write;
          last_d        <= win_d;
          cnt           <= '0;
          state         <= win_d ? ISSUE_D : ISSUE_I;
        end
        ISSUE_I, ISSUE_D: if (mem_busywait) begin
          state <= on_d ? WAIT_D : WAIT_I;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          arb_err   <= 1'b1;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (on_d) d_readdata <= '0;
          else i_readdata <= '0;
          state     <= on_d ? RESP_D : RESP_I;
        end else begin
          cnt <= cnt + CW'(1);
        end
        WAIT_I, WAIT_D: if (!mem_busywait) begin
          if (mem_read && on_d) d_readdata <= mem_readdata;
          if (mem_read && !on_d) i_readdata <= mem_readdata;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= on_d ? RESP_D : RESP_I;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a latency-programmable memory model and a transaction-level arbiter model.
module tb_mem_arbiter;
  localparam int AW = 6, DW = 32, TO = 4;
  logic CLK = 0, RESET = 0;
  logic i_read = 0, d_read = 0, d_write = 0;
  logic [AW-1:0] i_address = '0, d_address = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [DW-1:0] i_readdata, d_readdata, mem_writedata;
  logic i_busywait, d_busywait, mem_read, mem_write, arb_err;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_readdata = '0;
  logic mem_busywait;
  int checks = 0, errors = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .arb_err(arb_err));

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mval(input logic [5:0] a);
    return (a == 6'h05) ? 32'hDEADBEEF : (32'hC0DE0000 | {26'd0, a});
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // memory: acks one cycle after a strobe, stays busy lat cycles, then ignores the lingering strobe for one cycle
  int lat = 5;
  bit nak = 0, force_busy = 0;
  logic mb_r = 0, cool = 0, mw = 0;
  int mcnt = 0, wr_cnt = 0;
  logic [5:0] ma = '0, wr_addr = '0;
  logic [31:0] mwd = '0, wr_data = '0;
  assign mem_busywait = mb_r | force_busy;
  always @(posedge CLK) begin
    if (mb_r) begin
      if (mcnt == 1) begin
        mb_r <= 0;
        cool <= 1;
        if (mw) begin
          wr_cnt  <= wr_cnt + 1;
          wr_addr <= ma;
          wr_data <= mwd;
        end else mem_readdata <= mval(ma);
      end else mcnt <= mcnt - 1;
    end else if (cool) cool <= 0;
    else if ((mem_read || mem_write) && !nak && !force_busy) begin
      mb_r <= 1;
      mcnt <= lat;
      ma   <= mem_address;
      mw   <= mem_write;
      mwd  <= mem_writedata;
    end
  end

  // transaction model: phase 0 idle, 1 access outstanding, 2 response cycle; owner 1 means D
  int m_ph = 0, m_t = 0;
  bit m_own = 0, m_last = 0, m_wr = 0, m_ack = 0, m_err = 0;
  logic [5:0] m_addr = '0;
  logic [31:0] m_wd = '0, m_ri = '0, m_rd = '0;
  initial forever begin
    @(posedge CLK or negedge RESET);
    if (!RESET) begin
      m_ph = 0; m_last = 0; m_err = 0; m_addr = '0; m_wr = 0; m_ri = '0; m_rd = '0;
    end else if (m_ph == 2) m_ph = 0;
    else if (m_ph == 0) begin
      if (!mem_busywait && (i_read || d_read || d_write)) begin
        m_own  = (d_read || d_write) && (!i_read || !m_last);
        m_last = m_own;
        m_addr = m_own ? d_address : i_address;
        m_wr   = m_own && d_write;
        m_wd   = d_writedata;
        m_ph   = 1; m_ack = 0; m_t = 0;
      end
    end else if (!m_ack) begin
      if (mem_busywait) m_ack = 1;
      else begin
        m_t++;
        if (m_t == TO) begin
          m_err = 1; m_ph = 2;
          if (m_own) m_rd = '0; else m_ri = '0;
        end
      end
    end else if (!mem_busywait) begin
      if (!m_wr) begin
        if (m_own) m_rd = mem_readdata; else m_ri = mem_readdata;
      end
      m_ph = 2;
    end
  end

  logic [5:0] g_log[$];
  bit prev_strb = 0;
  initial forever begin
    @(posedge CLK); #1;
    chk("i_busywait", i_busywait, i_read & !(m_ph == 2 && !m_own));
    chk("d_busywait", d_busywait, (d_read | d_write) & !(m_ph == 2 && m_own));
    chk("mem_read", mem_read, m_ph == 1 && !m_wr);
    chk("mem_write", mem_write, m_ph == 1 && m_wr);
    chk("mem_address", mem_address, m_addr);
    if (m_ph == 1 && m_wr) chk("mem_writedata", mem_writedata, m_wd);
    chk("i_readdata", i_readdata, m_ri);
    chk("d_readdata", d_readdata, m_rd);
    chk("arb_err", arb_err, m_err);
    if ((mem_read || mem_write) && !prev_strb) g_log.push_back(mem_address);
    prev_strb = mem_read || mem_write;
  end

  task automatic wait_low(input bit d, output int n);
    n = 0;
    #1;
    while ((d ? d_busywait : i_busywait) !== 1'b0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_low timeout on port %s", d ? "D" : "I");
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK) RESET = 0;
    repeat (2) @(negedge CLK);
    RESET = 1;
  endtask

  logic [5:0] exp4 [4] = '{6'h20, 6'h10, 6'h20, 6'h10};
  int n;
  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_arb_err", arb_err, 0);
    chk("rst_i_readdata", i_readdata, 0);
    RESET = 1;
    @(negedge CLK);
    // single I read
    lat = 5; i_address = 6'h05; i_read = 1;
    wait_low(0, n);
    chk("t1_latency", n, 8);
    chk("t1_rdata", i_readdata, 32'hDEADBEEF);
    chk("t1_nowrite", wr_cnt, 0);
    i_read = 0;
    repeat (3) @(negedge CLK);
    // single D write
    lat = 3; d_address = 6'h3F; d_writedata = 32'h12345678; d_write = 1;
    wait_low(1, n);
    chk("t2_rdata_kept", d_readdata, 0);
    d_write = 0;
    repeat (3) @(negedge CLK);
    chk("t2_wr_cnt", wr_cnt, 1);
    chk("t2_wr_addr", wr_addr, 6'h3F);
    chk("t2_wr_data", wr_data, 32'h12345678);
    // simultaneous after reset: D first
    apply_reset();
    g_log.delete();
    lat = 2; i_address = 6'h10; d_address = 6'h20; i_read = 1; d_read = 1;
    wait_low(1, n);
    chk("t3_i_stalled", i_busywait, 1);
    chk("t3_d_rdata", d_readdata, mval(6'h20));
    d_read = 0;
    @(negedge CLK);
    chk("t3_gap", mem_read, 0);
    @(negedge CLK);
    chk("t3_i_grant", mem_read, 1);
    chk("t3_i_addr", mem_address, 6'h10);
    wait_low(0, n);
    chk("t3_i_rdata", i_readdata, mval(6'h10));
    i_read = 0;
    chk("t3_grants", g_log.size(), 2);
    chk("t3_first", g_log[0], 6'h20);
    repeat (2) @(negedge CLK);
    // back-to-back contention
    g_log.delete();
    i_read = 1; d_read = 1; n = 0;
    while (g_log.size() < 4 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL t4 timeout: %0d grants seen, 4 required", g_log.size());
    end
    i_read = 0; d_read = 0;
    for (int k = 0; k < 4; k++) chk($sformatf("t4_grant%0d", k), g_log[k], exp4[k]);
    repeat (20) @(negedge CLK);
    // watchdog
    lat = 3; i_address = 6'h05; i_read = 1;
    wait_low(0, n);
    chk("t5_pre_rdata", i_readdata, 32'hDEADBEEF);
    i_read = 0;
    repeat (2) @(negedge CLK);
    nak = 1; i_address = 6'h07; i_read = 1;
    wait_low(0, n);
    chk("t5_latency", n, 5);
    chk("t5_err", arb_err, 1);
    chk("t5_rdata", i_readdata, 0);
    i_read = 0; nak = 0;
    repeat (5) @(negedge CLK);
    chk("t5_sticky", arb_err, 1);
    // reset mid-access
    lat = 6; d_address = 6'h2A; d_read = 1; n = 0;
    while (!mem_busywait && n < 50) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    force_busy = 1; RESET = 0;
    #1;
    chk("t6_mem_read", mem_read, 0);
    chk("t6_mem_address", mem_address, 0);
    chk("t6_arb_err", arb_err, 0);
    chk("t6_d_rdata", d_readdata, 0);
    @(negedge CLK);
    RESET = 1; n = 0;
    while (mb_r && n < 50) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    chk("t6_no_grant", mem_read, 0);
    force_busy = 0;
    @(negedge CLK);
    chk("t6_grant", mem_read, 1);
    chk("t6_grant_addr", mem_address, 6'h2A);
    wait_low(1, n);
    chk("t6_rdata", d_readdata, mval(6'h2A));
    d_read = 0;
    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
